uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the FPGA UART path, the transmit-side counterpart of the UART receiver. Accepts words from the crossbar over a valid/ready handshake, holds one word in a single-entry buffer, and serialises frames onto `tx_sig`: one start bit, DATA_WIDTH data bits LSB first, one stop bit, no parity. Frames can run back-to-back with no idle gap while the buffer is kept full.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- BAUD_RATE, 115200, line bit rate
- CLK_FREQ, 100_000_000, clk frequency in Hz
- PULSE_WIDTH (localparam), CLK_FREQ/BAUD_RATE truncated, clk cycles per bit; must be ≥ 2

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- actuator_data  in  DATA_WIDTH  word from crossbar
- actuator_valid  in  1  actuator_data valid
- actuator_ready  out  1  buffer can accept a word
- tx_sig  out  1  serial line, idle high, registered
- tx_busy  out  1  frame in progress or word buffered

## Operation
- Buffer: buf_r, buf_valid. Handshake when actuator_valid && actuator_ready at a rising edge: buf_r ← actuator_data, buf_valid ← 1.
- actuator_ready = !buf_valid (combinational from the register). The buffer is never loaded and unloaded on the same edge.
- tx_busy = (state != IDLE) || buf_valid.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_sig = 1. If buf_valid: shift_r ← buf_r, buf_valid ← 0, tx_sig ← 0, clk_cnt ← PULSE_WIDTH-1, go to START.
  - START: when clk_cnt == 0: tx_sig ← shift_r[0], bit_cnt ← 0, clk_cnt ← PULSE_WIDTH-1, go to DATA. Otherwise decrement clk_cnt.
  - DATA: when clk_cnt == 0:
    - If bit_cnt == DATA_WIDTH-1: tx_sig ← 1, go to STOP.
    - Otherwise: shift_r ← shift_r >> 1, tx_sig ← next bit, bit_cnt ← bit_cnt + 1.
    - Reload clk_cnt ← PULSE_WIDTH-1 in both cases.
  - STOP: when clk_cnt == 0:
    - If buf_valid: perform the IDLE load action and go directly to START.
    - Otherwise go to IDLE.
  - Illegal state: go to IDLE, tx_sig ← 1.
- Widths: clk_cnt is $clog2(PULSE_WIDTH) bits; bit_cnt is $clog2(DATA_WIDTH)+1 bits. Counters never wrap below 0.
- actuator_data is sampled only at the handshake edge. Changes on it at any other time have no effect.

## Timing
- Reset values: tx_sig = 1, buf_valid = 0 (actuator_ready = 1), tx_busy = 0, state = IDLE, all counters and shift_r = 0.
- Handshake at edge E while in IDLE: tx_sig falls at edge E+1.
- Each bit, start and stop included, lasts exactly PULSE_WIDTH cycles. A frame is (DATA_WIDTH+2)·PULSE_WIDTH cycles.
- Back-to-back frames: if buf_valid is set before the final stop-bit cycle, the next start bit begins at the edge right after the stop bit ends, with zero idle cycles.
- actuator_ready rises on the edge after the FSM takes the buffered word. A second word can therefore be accepted during the start bit of the current frame.
- Reset asserted mid-frame: tx_sig goes high immediately (asynchronously). The frame in progress and the buffered word are discarded.

## Structure
- Shared package uart_pkg holds:
  - the tx state enum (logic [1:0]) and the rx state enum;
  - the function pulse_width(clk_freq, baud_rate) used by both uart_rx and uart_tx.
- One sub-module is natural: uart_bit_timer, a reloadable down-counter with load/expire outputs. It can be reused later by uart_rx.

## Test plan
- Single word 0xA5, default params → tx_sig low 1 cycle after the handshake edge, then bits 0,1,0,1,0,0,1,0,1,1 at 868 cycles each; tx_busy deasserts after 8680 cycles.
- actuator_valid held with 0x00 then 0xFF → second start bit immediately follows the first stop bit, no gap; actuator_ready low from the accept edge until frame 1 starts.
- Three words offered continuously → third word is accepted only once frame 2 takes the buffer; all three frames are contiguous and correct.
- rstn pulsed low during data bit 3 of 0x3C → tx_sig = 1 and actuator_ready = 1 at once; no further transitions; tx_busy = 0.
- Loopback into uart_rx with sensor_ready = 1, 32 random bytes → received sensor_data sequence matches the sent sequence exactly.
- CLK_FREQ = 8, BAUD_RATE = 2, DATA_WIDTH = 5, word 5'b10110 → 28-cycle frame, 4 cycles per bit, LSB-first order 0,1,1,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit and receive FSM state encodings and the helper that
// turns clock frequency and baud rate into clk cycles per bit.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // clk cycles per line bit, truncated
  function automatic int pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter.
//   clk, rstn : clock, async active-low reset
//   load      : reload the counter with PULSE_WIDTH-1
//   expire    : counter is at zero (last cycle of the current bit)
// The counter holds at zero rather than wrapping.
module uart_bit_timer #(
  parameter int PULSE_WIDTH = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(PULSE_WIDTH);

  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 clk_cnt <= '0;
    else if (load)             clk_cnt <= CW'(PULSE_WIDTH - 1);
    else if (clk_cnt != '0)    clk_cnt <= clk_cnt - CW'(1);
  end

  assign expire = (clk_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
//   clk, rstn      : clock, async active-low reset
//   actuator_data  : word from the crossbar, sampled only at the handshake
//   actuator_valid : actuator_data valid
//   actuator_ready : single-entry buffer is empty
//   tx_sig         : serial line, idle high, registered
//   tx_busy        : frame in progress or word buffered
// A word waiting in the buffer when the stop bit ends starts the next
// frame on the following edge, so frames run back-to-back with no gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] actuator_data,
  input  logic                  actuator_valid,
  output logic                  actuator_ready,
  output logic                  tx_sig,
  output logic                  tx_busy
);

  localparam int PULSE_WIDTH = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int BW          = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] buf_r;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [BW-1:0]         bit_cnt;
  logic                  load;
  logic                  expire;

  assign actuator_ready = !buf_valid;
  assign tx_busy        = (state != TX_IDLE) || buf_valid;

  // Reload on every bit boundary, and on leaving IDLE/STOP with a new word.
  assign load = (state == TX_IDLE && buf_valid) ||
                (expire && (state == TX_START || state == TX_DATA ||
                            (state == TX_STOP && buf_valid)));

  uart_bit_timer #(.PULSE_WIDTH(PULSE_WIDTH)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load),
    .expire (expire)
  );

  // The buffer only loads when empty and the FSM only takes it when full,
  // so the two buf_valid updates below can never collide on one edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= TX_IDLE;
      tx_sig    <= 1'b1;
      buf_r     <= '0;
      buf_valid <= 1'b0;
      shift_r   <= '0;
      bit_cnt   <= '0;
    end else begin
      if (actuator_valid && !buf_valid) begin
        buf_r     <= actuator_data;
        buf_valid <= 1'b1;
      end
      case (state)
        TX_IDLE: begin
          tx_sig <= 1'b1;
          if (buf_valid) begin
            shift_r   <= buf_r;
            buf_valid <= 1'b0;
            tx_sig    <= 1'b0;
            state     <= TX_START;
          end
        end
        TX_START: if (expire) begin
          tx_sig  <= shift_r[0];
          bit_cnt <= '0;
          state   <= TX_DATA;
        end
        TX_DATA: if (expire) begin
          if (bit_cnt == LAST_BIT) begin
            tx_sig <= 1'b1;
            state  <= TX_STOP;
          end else begin
            shift_r <= shift_r >> 1;
            tx_sig  <= shift_r[1];
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        TX_STOP: if (expire) begin
          if (buf_valid) begin
            shift_r   <= buf_r;
            buf_valid <= 1'b0;
            tx_sig    <= 1'b0;
            state     <= TX_START;
          end else begin
            state <= TX_IDLE;
          end
        end
        default: begin
          state  <= TX_IDLE;
          tx_sig <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at default parameters
// (868 cycles/bit) and one small instance (4 cycles/bit, 5 data bits).
module tb_uart_tx;

  localparam int DPW = 868;
  localparam int SPW = 4;
  localparam int SFR = 7 * SPW;   // small frame length in cycles

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] d_data;
  logic       d_valid, d_ready, d_tx, d_busy;
  logic [4:0] s_data;
  logic       s_valid, s_ready, s_tx, s_busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uart_tx u_dut_d (
    .clk(clk), .rstn(rstn), .actuator_data(d_data), .actuator_valid(d_valid),
    .actuator_ready(d_ready), .tx_sig(d_tx), .tx_busy(d_busy)
  );

  uart_tx #(.DATA_WIDTH(5), .BAUD_RATE(2), .CLK_FREQ(8)) u_dut_s (
    .clk(clk), .rstn(rstn), .actuator_data(s_data), .actuator_valid(s_valid),
    .actuator_ready(s_ready), .tx_sig(s_tx), .tx_busy(s_busy)
  );

  task test_reset;
    repeat (3) @(negedge clk);
    vecs++; if (d_tx !== 1'b1)    begin errs++; $display("FAIL reset d_tx: got %b want 1", d_tx); end
    vecs++; if (d_ready !== 1'b1) begin errs++; $display("FAIL reset d_ready: got %b want 1", d_ready); end
    vecs++; if (d_busy !== 1'b0)  begin errs++; $display("FAIL reset d_busy: got %b want 0", d_busy); end
    vecs++; if (s_tx !== 1'b1)    begin errs++; $display("FAIL reset s_tx: got %b want 1", s_tx); end
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset s_ready: got %b want 1", s_ready); end
    vecs++; if (s_busy !== 1'b0)  begin errs++; $display("FAIL reset s_busy: got %b want 0", s_busy); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task test_single_a5;
    logic [9:0] fr;
    int nbad;
    fr = {1'b1, 8'hA5, 1'b0};
    nbad = 0;
    d_data = 8'hA5; d_valid = 1'b1;
    vecs++; if (d_ready !== 1'b1) begin errs++; $display("FAIL a5 ready_pre: got %b want 1", d_ready); end
    @(negedge clk);
    d_valid = 1'b0; d_data = 8'h00;
    vecs++; if (d_ready !== 1'b0) begin errs++; $display("FAIL a5 ready_held: got %b want 0", d_ready); end
    vecs++; if (d_tx !== 1'b1)    begin errs++; $display("FAIL a5 tx_pre: got %b want 1", d_tx); end
    vecs++; if (d_busy !== 1'b1)  begin errs++; $display("FAIL a5 busy_held: got %b want 1", d_busy); end
    for (int k = 0; k < 10 * DPW; k++) begin
      @(negedge clk);
      vecs++;
      if (d_tx !== fr[k / DPW] || d_busy !== 1'b1 || d_ready !== 1'b1) begin
        errs++;
        if (nbad++ < 3)
          $display("FAIL a5 frame cyc %0d: got tx=%b busy=%b ready=%b want tx=%b busy=1 ready=1",
                   k, d_tx, d_busy, d_ready, fr[k / DPW]);
      end
    end
    @(negedge clk);
    vecs++; if (d_busy !== 1'b0) begin errs++; $display("FAIL a5 busy_end: got %b want 0", d_busy); end
    vecs++; if (d_tx !== 1'b1)   begin errs++; $display("FAIL a5 tx_end: got %b want 1", d_tx); end
  endtask

  task test_small_frame;
    logic [6:0] fr;
    int nbad;
    fr = {1'b1, 5'b10110, 1'b0};
    nbad = 0;
    s_data = 5'b10110; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_data = 5'b00000;
    for (int k = 0; k < SFR; k++) begin
      @(negedge clk);
      vecs++;
      if (s_tx !== fr[k / SPW] || s_busy !== 1'b1) begin
        errs++;
        if (nbad++ < 3)
          $display("FAIL small_frame cyc %0d: got tx=%b busy=%b want tx=%b busy=1",
                   k, s_tx, s_busy, fr[k / SPW]);
      end
    end
    @(negedge clk);
    vecs++; if (s_busy !== 1'b0 || s_tx !== 1'b1)
      begin errs++; $display("FAIL small_frame end: got tx=%b busy=%b want tx=1 busy=0", s_tx, s_busy); end
  endtask

  task test_back_to_back;
    logic [13:0] st;
    int nbad;
    st = {1'b1, 5'h1F, 1'b0, 1'b1, 5'h00, 1'b0};
    nbad = 0;
    s_data = 5'h00; s_valid = 1'b1;
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL b2b ready_pre: got %b want 1", s_ready); end
    @(negedge clk);
    vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL b2b ready_accept: got %b want 0", s_ready); end
    s_data = 5'h1F;
    for (int k = 0; k < 2 * SFR; k++) begin
      @(negedge clk);
      vecs++;
      if (s_tx !== st[k / SPW]) begin
        errs++;
        if (nbad++ < 3) $display("FAIL b2b stream cyc %0d: got %b want %b", k, s_tx, st[k / SPW]);
      end
      if (k == 0) begin
        vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL b2b ready_taken: got %b want 1", s_ready); end
      end
      if (k == 1) begin
        vecs++; if (s_ready !== 1'b0) begin errs++; $display("FAIL b2b ready_second: got %b want 0", s_ready); end
        s_valid = 1'b0; s_data = 5'h0A;
      end
      if (k == SFR) begin
        vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL b2b ready_frame2: got %b want 1", s_ready); end
      end
    end
    @(negedge clk);
    vecs++; if (s_busy !== 1'b0 || s_tx !== 1'b1)
      begin errs++; $display("FAIL b2b end: got tx=%b busy=%b want tx=1 busy=0", s_tx, s_busy); end
  endtask

  task test_three_words;
    logic [4:0]  w [3];
    logic [20:0] st;
    int acc [3];
    int idx, nbad;
    bit pend;
    w[0] = 5'h15; w[1] = 5'h0A; w[2] = 5'h13;
    st = {1'b1, 5'h13, 1'b0, 1'b1, 5'h0A, 1'b0, 1'b1, 5'h15, 1'b0};
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    nbad = 0;
    s_data = w[0]; s_valid = 1'b1;
    @(negedge clk);
    idx = 1; s_data = w[1]; pend = 1'b0;
    for (int k = 0; k < 3 * SFR; k++) begin
      @(negedge clk);
      vecs++;
      if (s_tx !== st[k / SPW]) begin
        errs++;
        if (nbad++ < 3) $display("FAIL three stream cyc %0d: got %b want %b", k, s_tx, st[k / SPW]);
      end
      if (pend) begin
        idx++;
        if (idx < 3) s_data = w[idx];
        else begin s_valid = 1'b0; s_data = 5'h00; end
        pend = 1'b0;
      end
      if (s_valid && s_ready && idx < 3) begin
        acc[idx] = k; pend = 1'b1;
      end
    end
    vecs++; if (acc[1] !== 0)   begin errs++; $display("FAIL three accept_w1: got cyc %0d want 0", acc[1]); end
    vecs++; if (acc[2] !== SFR) begin errs++; $display("FAIL three accept_w2: got cyc %0d want %0d", acc[2], SFR); end
    @(negedge clk);
    vecs++; if (s_busy !== 1'b0 || s_tx !== 1'b1)
      begin errs++; $display("FAIL three end: got tx=%b busy=%b want tx=1 busy=0", s_tx, s_busy); end
  endtask

  task test_reset_start;
    s_data = 5'h00; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    vecs++; if (s_tx !== 1'b0) begin errs++; $display("FAIL rst_start tx_pre: got %b want 0", s_tx); end
    rstn = 1'b0;
    #1;
    vecs++; if (s_tx !== 1'b1)    begin errs++; $display("FAIL rst_start tx_async: got %b want 1", s_tx); end
    vecs++; if (s_busy !== 1'b0)  begin errs++; $display("FAIL rst_start busy: got %b want 0", s_busy); end
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL rst_start ready: got %b want 1", s_ready); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      vecs++;
      if (s_tx !== 1'b1 || s_busy !== 1'b0) begin
        errs++; $display("FAIL rst_start quiet cyc %0d: got tx=%b busy=%b want tx=1 busy=0", k, s_tx, s_busy);
      end
    end
  endtask

  task test_reset_midframe;
    int nbad;
    nbad = 0;
    d_data = 8'h3C; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    for (int k = 0; k < 4 * DPW + 400; k++) begin
      @(negedge clk);
      if (k == 0) begin d_valid = 1'b1; d_data = 8'h00; end
      if (k == 1) d_valid = 1'b0;
    end
    vecs++; if (d_tx !== 1'b1)    begin errs++; $display("FAIL rst_mid tx_bit3: got %b want 1", d_tx); end
    vecs++; if (d_ready !== 1'b0) begin errs++; $display("FAIL rst_mid ready_pre: got %b want 0", d_ready); end
    vecs++; if (d_busy !== 1'b1)  begin errs++; $display("FAIL rst_mid busy_pre: got %b want 1", d_busy); end
    rstn = 1'b0;
    #1;
    vecs++; if (d_tx !== 1'b1)    begin errs++; $display("FAIL rst_mid tx: got %b want 1", d_tx); end
    vecs++; if (d_ready !== 1'b1) begin errs++; $display("FAIL rst_mid ready: got %b want 1", d_ready); end
    vecs++; if (d_busy !== 1'b0)  begin errs++; $display("FAIL rst_mid busy: got %b want 0", d_busy); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      vecs++;
      if (d_tx !== 1'b1 || d_busy !== 1'b0) begin
        errs++;
        if (nbad++ < 3)
          $display("FAIL rst_mid quiet cyc %0d: got tx=%b busy=%b want tx=1 busy=0", k, d_tx, d_busy);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    d_data = '0; d_valid = 1'b0;
    s_data = '0; s_valid = 1'b0;
    test_reset;
    test_single_a5;
    test_small_frame;
    test_back_to_back;
    test_three_words;
    test_reset_start;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
